// File: rtl/param_serial_to_parallel_rx.sv
// Serial-to-parallel receiver with per-word bit-order lock, single-word
// hold register, sticky overrun flag and synchronous clear.
`timescale 1ns/1ps
module param_serial_to_parallel_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_n,
    input  logic             ser_in,
    input  logic             bit_en_n,
    input  logic             direction,
    input  logic             rd_n,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] sr_r, sr_next_s;
    logic [CW-1:0]    cnt_r, cnt_next_s;
    logic             dir_q_r, dir_q_next_s;
    logic [WIDTH-1:0] data_out_r, data_out_next_s;
    logic             valid_r, valid_next_s;
    logic             overrun_r, overrun_next_s;
    logic             busy_r;
    logic             eff_dir_s;
    logic             complete_s;

    // Bit order for the current strobe: live input on the first bit, locked copy afterwards
    always_comb begin
        eff_dir_s = direction;
        case (state_r)
            IDLE:    eff_dir_s = direction;
            SHIFT:   eff_dir_s = dir_q_r;
            default: eff_dir_s = direction;
        endcase
    end

    // Next-state logic: clear has top priority, then shifting, then hold-register update
    always_comb begin
        state_next_s    = state_r;
        sr_next_s       = sr_r;
        cnt_next_s      = cnt_r;
        dir_q_next_s    = dir_q_r;
        data_out_next_s = data_out_r;
        valid_next_s    = valid_r;
        overrun_next_s  = overrun_r;
        complete_s      = 1'b0;

        if (!clr_n) begin
            state_next_s    = IDLE;
            sr_next_s       = {WIDTH{1'b0}};
            cnt_next_s      = {CW{1'b0}};
            dir_q_next_s    = 1'b0;
            data_out_next_s = {WIDTH{1'b0}};
            valid_next_s    = 1'b0;
            overrun_next_s  = 1'b0;
        end else begin
            if (!bit_en_n) begin
                dir_q_next_s = eff_dir_s;
                if (eff_dir_s) begin
                    sr_next_s = {sr_r[WIDTH-2:0], ser_in};
                end else begin
                    sr_next_s = {ser_in, sr_r[WIDTH-1:1]};
                end
                if (cnt_r == LAST_CNT) begin
                    complete_s   = 1'b1;
                    cnt_next_s   = {CW{1'b0}};
                    state_next_s = IDLE;
                end else begin
                    cnt_next_s   = cnt_r + ONE_CNT;
                    state_next_s = SHIFT;
                end
            end else begin
                complete_s = 1'b0;
            end

            // A word completing while an unread word is held (and not being read) is dropped
            if (complete_s) begin
                if (!valid_r || !rd_n) begin
                    data_out_next_s = sr_next_s;
                    valid_next_s    = 1'b1;
                end else begin
                    overrun_next_s  = 1'b1;
                end
            end else if (!rd_n && valid_r) begin
                valid_next_s = 1'b0;
            end else begin
                valid_next_s = valid_r;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            sr_r       <= {WIDTH{1'b0}};
            cnt_r      <= {CW{1'b0}};
            dir_q_r    <= 1'b0;
            data_out_r <= {WIDTH{1'b0}};
            valid_r    <= 1'b0;
            overrun_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            sr_r       <= sr_next_s;
            cnt_r      <= cnt_next_s;
            dir_q_r    <= dir_q_next_s;
            data_out_r <= data_out_next_s;
            valid_r    <= valid_next_s;
            overrun_r  <= overrun_next_s;
            busy_r     <= (state_next_s == SHIFT);
        end
    end

    assign data_out = data_out_r;
    assign valid    = valid_r;
    assign overrun  = overrun_r;
    assign busy     = busy_r;

endmodule

// File: doc/param_serial_to_parallel_rx.md
PARAM_SERIAL_TO_PARALLEL_RX -- requirements
Module: param_serial_to_parallel_rx

Interface
REQ-001 Parameter: WIDTH, default 4, word length in bits; SHALL support WIDTH >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 clr_n  input  1  synchronous active-low clear/abort.
REQ-005 ser_in  input  1  serial data bit.
REQ-006 bit_en_n  input  1  active-low bit strobe; ser_in SHALL be sampled only on edges where bit_en_n=0.
REQ-007 direction  input  1  bit order: 1 = MSB first (sender shifting left), 0 = LSB first (sender shifting right).
REQ-008 rd_n  input  1  active-low read acknowledge for the held word.
REQ-009 data_out  output  WIDTH  last completed word (registered).
REQ-010 valid  output  1  data_out holds an unread word.
REQ-011 overrun  output  1  sticky flag: a completed word was dropped.
REQ-012 busy  output  1  a word is partially received (bit count != 0).

Function
REQ-013 Internal state SHALL be: shift register sr[WIDTH], bit counter cnt (0..WIDTH-1), locked direction bit dir_q, plus the output registers.
REQ-014 Two states: IDLE (cnt=0), SHIFT (cnt 1..WIDTH-1); busy SHALL be 1 exactly in SHIFT.
REQ-015 On a strobed edge in IDLE, dir_q SHALL load direction; in SHIFT, direction SHALL be ignored until the word completes.
REQ-016 MSB-first insertion (effective dir=1): sr <= {sr[WIDTH-2:0], ser_in}.
REQ-017 LSB-first insertion (effective dir=0): sr <= {ser_in, sr[WIDTH-1:1]}.
REQ-018 Effective dir SHALL be direction on the first bit of a word and dir_q on all later bits.
REQ-019 Each strobed edge SHALL increment cnt; the WIDTH-th strobed bit SHALL complete the word and wrap cnt to 0 (IDLE).
REQ-020 Non-strobed edges (bit_en_n=1) SHALL hold sr, cnt and dir_q; strobes need not be contiguous.
REQ-021 On completion, the assembled word (sr including the final bit) SHALL be written to data_out and valid set on the same edge; latency: word visible the cycle after the last strobed edge.
REQ-022 On an edge with rd_n=0 and valid=1, valid SHALL clear unless a word completes on that same edge.
REQ-023 Completion with valid=0, or with valid=1 and rd_n=0: data_out SHALL load the new word and valid SHALL be 1; overrun unchanged.
REQ-024 Completion with valid=1 and rd_n=1: the new word SHALL be discarded, data_out and valid held, overrun set to 1.
REQ-025 overrun SHALL remain 1 until clr_n=0 or rst_n=0; rd_n SHALL NOT clear it.
REQ-026 rd_n=0 with valid=0 SHALL have no effect.
REQ-027 clr_n=0 SHALL have priority over all other inputs: on that edge sr, cnt, dir_q, data_out, valid, overrun SHALL all become 0 and any strobed bit SHALL be ignored.

Reset
REQ-028 rst_n=0 SHALL immediately, without a clock edge, force sr=0, cnt=0, dir_q=0, data_out=0, valid=0, overrun=0, busy=0.
REQ-029 Reset asserted mid-word SHALL discard the partial word; the first strobed bit after release SHALL start a new word with direction resampled.
REQ-030 Release of rst_n SHALL produce no output change until a subsequent clock edge with qualifying inputs.

Verification (WIDTH=4)
REQ-031 direction=1, ser_in 1,0,1,1 on 4 consecutive strobes -> data_out=4'b1011, valid=1 the next cycle; busy high for the 3 cycles after strobes 1-3.
REQ-032 direction=0, ser_in 1,0,1,1 -> data_out=4'b1101; direction toggled after bit 1 -> same result (locked).
REQ-033 Word 4'hA completed, no read, second word 4'h5 completed -> data_out stays 4'hA, valid=1, overrun=1; rd_n=0 -> valid=0, overrun stays 1; clr_n=0 -> overrun=0.
REQ-034 rd_n=0 on the same edge as completion of 4'h3 while holding 4'hC -> data_out=4'h3, valid=1, overrun=0.
REQ-035 Strobes interleaved with idle cycles (bit_en_n=1 gaps of 0-3 cycles) -> same word as contiguous case.
REQ-036 rst_n pulsed low asynchronously after 2 bits -> all outputs 0 immediately; next 4 bits 0,1,1,0 (direction=1) -> data_out=4'b0110.
